sram_model: RTL and testbench

SRAM_MODEL -- requirements
Module: sram_model

---
 rtl/sram_model.sv | 162 ++++++++++++++++
 tb/tb_sram_model.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_model.sv
// Cycle-based model of a 16-bit asynchronous SRAM with byte lanes, a
// configurable read latency, access counters and a sticky out-of-range flag.
module sram_model #(
  parameter int ADR_W  = 10,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_adr,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        addr_err,
  output logic        dq_drive
);

  localparam int DEPTH = 1 << ADR_W;

  logic [15:0]      mem_q [DEPTH];
  logic [ADR_W-1:0] idx;
  logic             wr_cyc;
  logic             rd_cyc;
  logic             oor;
  logic [15:0]      rd_word;
  logic [15:0]      wr_count_q;
  logic [15:0]      wr_count_d;
  logic [15:0]      rd_count_q;
  logic [15:0]      rd_count_d;
  logic             addr_err_q;
  logic             addr_err_d;
  logic             src_vld;
  logic [15:0]      src_dat;
  logic             drv_lo;
  logic             drv_hi;

  // Byte-lane merge of a write into the stored word; a deasserted lane keeps its old byte.
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_w,
                                              input logic [15:0] new_w,
                                              input logic        ub_n,
                                              input logic        lb_n);
    logic [15:0] res;
    res = old_w;
    if (!lb_n) res[7:0]  = new_w[7:0];
    if (!ub_n) res[15:8] = new_w[15:8];
    return res;
  endfunction

  assign idx     = SRAM_adr[ADR_W-1:0];
  assign wr_cyc  = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_cyc  = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign oor     = |SRAM_adr[17:ADR_W];
  assign rd_word = mem_q[idx];

  // Storage: no reset on the array, and a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_cyc) begin
      mem_q[idx] <= merge_lanes(mem_q[idx], SRAM_DQ, SRAM_UB_N, SRAM_LB_N);
    end
  end

  // Next-state for counters and the sticky range flag.
  always_comb begin
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    addr_err_d = addr_err_q;
    if (wr_cyc) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
    if (rd_cyc) begin
      rd_count_d = rd_count_q + 16'd1;
    end else begin
      rd_count_d = rd_count_q;
    end
    if ((wr_cyc || rd_cyc) && oor) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = addr_err_q;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count_q <= 16'd0;
      rd_count_q <= 16'd0;
      addr_err_q <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      addr_err_q <= addr_err_d;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_comb
      assign src_vld = 1'b1;
      assign src_dat = rd_word;
    end else begin : g_pipe
      logic [RD_LAT-1:0] vld_q;
      logic [RD_LAT-1:0] vld_d;
      logic [15:0]       dat_q [RD_LAT];
      logic [15:0]       dat_d [RD_LAT];

      // Data is snapshotted at the read edge, so a same-edge write cannot leak into it.
      always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_cyc;
        dat_d[0] = rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
          vld_d[i] = vld_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end

      // Read pipeline registers; reset invalidates any read in flight.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= '0;
          for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= 16'd0;
          end
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= dat_d[i];
          end
        end
      end

      assign src_vld = vld_q[RD_LAT-1];
      assign src_dat = dat_q[RD_LAT-1];
    end
  endgenerate

  // Lane drive follows the live control pins so the bus is released within the cycle.
  always_comb begin
    drv_lo = 1'b0;
    drv_hi = 1'b0;
    if (rst && rd_cyc && src_vld) begin
      drv_lo = !SRAM_LB_N;
      drv_hi = !SRAM_UB_N;
    end else begin
      drv_lo = 1'b0;
      drv_hi = 1'b0;
    end
  end

  assign SRAM_DQ[7:0]  = drv_lo ? src_dat[7:0]  : 8'hzz;
  assign SRAM_DQ[15:8] = drv_hi ? src_dat[15:8] : 8'hzz;
  assign dq_drive      = drv_lo | drv_hi;
  assign wr_count      = wr_count_q;
  assign rd_count      = rd_count_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_sram_model.sv
// Three sram_model instances (read latency 0, 1 and 3) on shared controls,
// checked every cycle against a word-array and read-history reference model.
module tb_sram_model;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } rec_t;

  localparam int LATS [3] = '{0, 1, 3};

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [17:0] adr  = 18'd0;
  logic        ub_n = 1'b1;
  logic        lb_n = 1'b1;
  logic        we_n = 1'b1;
  logic        ce_n = 1'b1;
  logic        oe_n = 1'b1;

  wire  [15:0] dq0;
  wire  [15:0] dq1;
  wire  [15:0] dq2;
  logic [15:0] tbv    [3];
  logic        tbe_lo [3];
  logic        tbe_hi [3];
  logic [15:0] dqo    [3];
  logic [15:0] wc     [3];
  logic [15:0] rc     [3];
  logic        ae     [3];
  logic        dd     [3];

  int          n_checks = 0;
  int          n_errors = 0;

  logic [15:0] mem_m [1024];
  rec_t        hist [$];
  logic [15:0] wcnt_m = 16'd0;
  logic [15:0] rcnt_m = 16'd0;
  logic        err_m  = 1'b0;
  logic [15:0] cur_wd = 16'd0;
  logic [15:0] exp_dq  [3];
  logic        exp_drv [3];

  always #5 clk = ~clk;

  assign dq0[7:0]  = tbe_lo[0] ? tbv[0][7:0]  : 8'hzz;
  assign dq0[15:8] = tbe_hi[0] ? tbv[0][15:8] : 8'hzz;
  assign dq1[7:0]  = tbe_lo[1] ? tbv[1][7:0]  : 8'hzz;
  assign dq1[15:8] = tbe_hi[1] ? tbv[1][15:8] : 8'hzz;
  assign dq2[7:0]  = tbe_lo[2] ? tbv[2][7:0]  : 8'hzz;
  assign dq2[15:8] = tbe_hi[2] ? tbv[2][15:8] : 8'hzz;
  assign dqo[0] = dq0;
  assign dqo[1] = dq1;
  assign dqo[2] = dq2;

  sram_model #(.ADR_W(10), .RD_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_adr(adr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_count(wc[0]), .rd_count(rc[0]), .addr_err(ae[0]), .dq_drive(dd[0]));

  sram_model #(.ADR_W(10), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_adr(adr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_count(wc[1]), .rd_count(rc[1]), .addr_err(ae[1]), .dq_drive(dd[1]));

  sram_model #(.ADR_W(10), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_adr(adr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_count(wc[2]), .rd_count(rc[2]), .addr_err(ae[2]), .dq_drive(dd[2]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    wcnt_m = 16'd0;
    rcnt_m = 16'd0;
    err_m  = 1'b0;
  endtask

  // One rising edge of the reference: record what a read would return, then apply a write.
  task automatic model_edge();
    rec_t       r;
    logic [9:0] a;
    r.v = 1'b0;
    r.d = 16'd0;
    a   = adr[9:0];
    if (rst) begin
      if (!ce_n && !oe_n && we_n) begin
        r.v    = 1'b1;
        r.d    = mem_m[a];
        rcnt_m = rcnt_m + 16'd1;
        if (adr[17:10] != 8'd0) err_m = 1'b1;
      end
      if (!ce_n && !we_n) begin
        if (!lb_n) mem_m[a][7:0]  = cur_wd[7:0];
        if (!ub_n) mem_m[a][15:8] = cur_wd[15:8];
        wcnt_m = wcnt_m + 16'd1;
        if (adr[17:10] != 8'd0) err_m = 1'b1;
      end
    end
    hist.push_front(r);
    while (hist.size() > 3) void'(hist.pop_back());
  endtask

  // Which lanes an instance of latency lat should be driving right now, and with what.
  task automatic expect_drive(input int lat, output logic lo, output logic hi, output logic [15:0] d);
    logic en;
    logic v;
    en = rst && !ce_n && !oe_n && we_n;
    if (lat == 0) begin
      v = 1'b1;
      d = mem_m[adr[9:0]];
    end else if (hist.size() >= lat) begin
      v = hist[lat-1].v;
      d = hist[lat-1].d;
    end else begin
      v = 1'b0;
      d = 16'd0;
    end
    lo = en && v && !lb_n;
    hi = en && v && !ub_n;
  endtask

  // Clock one edge, present new pins just after it, and check all instances mid-cycle.
  task automatic apply(input logic r, input logic we, input logic ce, input logic oe,
                       input logic ub, input logic lb, input logic [17:0] a, input logic [15:0] wd);
    logic        lo;
    logic        hi;
    logic [15:0] d;
    logic [15:0] noise;
    @(posedge clk);
    model_edge();
    #1;
    rst = r;
    if (!r) model_reset();
    we_n = we; ce_n = ce; oe_n = oe; ub_n = ub; lb_n = lb; adr = a; cur_wd = wd;
    for (int i = 0; i < 3; i++) begin
      expect_drive(LATS[i], lo, hi, d);
      noise      = we ? 16'($urandom) : wd;
      tbv[i]     = noise;
      tbe_lo[i]  = !lo;
      tbe_hi[i]  = !hi;
      exp_dq[i]  = {hi ? d[15:8] : noise[15:8], lo ? d[7:0] : noise[7:0]};
      exp_drv[i] = lo | hi;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("dq_l%0d", LATS[i]), 32'(dqo[i]), 32'(exp_dq[i]));
      check_eq($sformatf("dq_drive_l%0d", LATS[i]), 32'(dd[i]), 32'(exp_drv[i]));
      check_eq($sformatf("wr_count_l%0d", LATS[i]), 32'(wc[i]), 32'(wcnt_m));
      check_eq($sformatf("rd_count_l%0d", LATS[i]), 32'(rc[i]), 32'(rcnt_m));
      check_eq($sformatf("addr_err_l%0d", LATS[i]), 32'(ae[i]), 32'(err_m));
    end
  endtask

  task automatic do_wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
    apply(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), ub, lb, a, d);
  endtask

  task automatic do_rd(input logic [17:0] a, input logic ub, input logic lb);
    apply(1'b1, 1'b1, 1'b0, 1'b0, ub, lb, a, 16'h0000);
  endtask

  task automatic do_idle();
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0000);
  endtask

  initial begin
    logic [17:0] a;
    int          op;
    for (int i = 0; i < 3; i++) begin
      tbv[i]    = 16'h0000;
      tbe_lo[i] = 1'b1;
      tbe_hi[i] = 1'b1;
    end
    model_reset();

    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 16'h0000);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 16'h0000);
    check_eq("reset_dq_drive", 32'(dd[0]), 32'd0);
    check_eq("reset_wr_count", 32'(wc[2]), 32'd0);
    do_idle();

    // Full write then read back with one cycle of latency.
    do_wr(18'h00004, 16'hA5A5, 1'b0, 1'b0);
    do_rd(18'h00004, 1'b0, 1'b0);
    do_rd(18'h00004, 1'b0, 1'b0);
    check_eq("full_rd_l1", 32'(dqo[1]), 32'h0000A5A5);
    check_eq("full_wr_count", 32'(wc[1]), 32'd1);
    check_eq("full_rd_count", 32'(rc[1]), 32'd1);

    for (int i = 0; i < 32; i++) do_wr(18'(i), 16'($urandom), 1'b0, 1'b0);

    // Byte lanes.
    do_wr(18'h00010, 16'h1234, 1'b0, 1'b0);
    do_wr(18'h00010, 16'hFFEE, 1'b1, 1'b0);
    do_rd(18'h00010, 1'b0, 1'b0);
    do_rd(18'h00010, 1'b0, 1'b0);
    check_eq("lane_merge_l1", 32'(dqo[1]), 32'h000012EE);
    do_rd(18'h00010, 1'b0, 1'b1);
    check_eq("lane_lo_off_l1", 32'(dqo[1]), 32'({8'h12, tbv[1][7:0]}));

    // Read snapshot taken at the read edge, independent of later writes.
    do_wr(18'h00008, 16'h0001, 1'b0, 1'b0);
    do_rd(18'h00008, 1'b0, 1'b0);
    do_rd(18'h00008, 1'b0, 1'b0);
    check_eq("snap_old_l1", 32'(dqo[1]), 32'h00000001);
    do_wr(18'h00008, 16'h0002, 1'b0, 1'b0);
    do_rd(18'h00008, 1'b0, 1'b0);
    do_rd(18'h00008, 1'b0, 1'b0);
    check_eq("snap_old_l3", 32'(dqo[2]), 32'h00000001);
    check_eq("snap_new_l1", 32'(dqo[1]), 32'h00000002);

    // Turnaround on the combinational instance.
    do_rd(18'h00003, 1'b0, 1'b0);
    check_eq("turn_drive_on", 32'(dd[0]), 32'd1);
    do_wr(18'h00003, 16'hBEEF, 1'b0, 1'b0);
    check_eq("turn_drive_off", 32'(dd[0]), 32'd0);
    check_eq("turn_bus_clean", 32'(dqo[0]), 32'h0000BEEF);

    // Out-of-range write aliases onto the low address bits.
    do_wr(18'h00404, 16'h5A5A, 1'b0, 1'b0);
    do_idle();
    check_eq("oor_flag", 32'(ae[1]), 32'd1);
    do_rd(18'h00004, 1'b0, 1'b0);
    do_rd(18'h00004, 1'b0, 1'b0);
    check_eq("oor_alias", 32'(dqo[1]), 32'h00005A5A);
    check_eq("oor_sticky", 32'(ae[2]), 32'd1);

    // Reset while a read is in flight, a write dropped during reset, memory retained.
    do_rd(18'h00004, 1'b0, 1'b0);
    do_rd(18'h00004, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00004, 16'h0000);
    check_eq("rst_abort_drive", 32'(dd[2]), 32'd0);
    check_eq("rst_rd_count", 32'(rc[2]), 32'd0);
    check_eq("rst_addr_err", 32'(ae[2]), 32'd0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00004, 16'hDEAD);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00004, 16'h0000);
    do_rd(18'h00004, 1'b0, 1'b0);
    do_rd(18'h00004, 1'b0, 1'b0);
    do_rd(18'h00004, 1'b0, 1'b0);
    check_eq("rst_mem_kept_l3", 32'(dqo[2]), 32'h00005A5A);
    check_eq("rst_first_edge_rd", 32'(rc[2]), 32'd3);
    check_eq("rst_wr_dropped", 32'(wc[2]), 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 99);
      a  = 18'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a[17:10] = 8'($urandom_range(1, 255));
      if (op < 3) begin
        apply(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), a, 16'($urandom));
      end else if (op < 40) begin
        do_wr(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (op < 80) begin
        do_rd(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (op < 90) begin
        apply(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
      end else begin
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), a, 16'h0000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
